regfile_write_sched: RTL and testbench
======================================

Name: regfile_write_sched

Overview:
- Scheduler for the single write port of the 32x32 general register file.
- Round-robin arbitration among NREQ writeback requesters (e.g. ALU, load, mult/div) using valid/ready handshakes.
- Sequenced clear: writes zero to every register, one per cycle, replacing an all-at-once reset clear.
- Drives regWrite/writeReg/writeData of the register file. Outputs are registered on posedge clock_in, so they are stable for the file's negedge write.

Parameters:
- NREQ, 3, number of writeback requesters (2..4).
- AW, 5, register address width.
- DW, 32, data width.
- NREG, 32, registers cleared by a clear sequence (must be at most 2**AW).

Ports:
- clock_in  in  1  system clock; all state updates on posedge.
- res_n  in  1  synchronous active-low reset, sampled on posedge clock_in.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed target register; requester i uses bits [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant, combinational from state and req_valid.
- clr_start  in  1  request a full register clear.
- clr_busy  out  1  clear sequence in progress.
- rf_we  out  1  to the register file's regWrite.
- rf_waddr  out  AW  to the register file's writeReg.
- rf_wdata  out  DW  to the register file's writeData.
- grant_id  out  2  index of the requester that produced the current rf_we pulse.

Behaviour:
- Reset (res_n=0 at posedge):
  - state=IDLE; rr_ptr=NREQ-1; clr_cnt=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, clr_busy=0.
  - req_ready=0 while res_n=0.
- States: IDLE (arbitrating) and CLEAR.
- IDLE, clr_start=1:
  - Next state is CLEAR; clr_cnt=0.
  - req_ready=0 this cycle; clear takes priority over pending requests.
- IDLE, clr_start=0:
  - Winner is the first i with req_valid[i]=1, searching from rr_ptr+1 upward with wrap modulo NREQ.
  - req_ready[winner]=1; all other ready bits are 0.
  - Transfer occurs when valid and ready are both 1.
  - Next posedge: rf_we=1, rf_waddr=req_addr[winner], rf_wdata=req_data[winner], grant_id=winner, rr_ptr=winner.
  - Latency: exactly 1 cycle from the transfer edge to rf_we. Throughput: 1 write per cycle.
  - No valid requester: next rf_we=0; rf_waddr and rf_wdata hold their values; rr_ptr is unchanged.
- Requester rules:
  - Once req_valid is asserted, it and its addr/data must hold until ready.
  - Dropping valid before ready is permitted; the request is simply not serviced.
- CLEAR:
  - Each cycle: rf_we=1, rf_waddr=clr_cnt, rf_wdata=0; clr_cnt increments.
  - After issuing address NREG-1, return to IDLE with clr_cnt=0.
  - req_ready=0 throughout; clr_start is ignored.
  - clr_busy=1 from the cycle after acceptance through the cycle holding the last write. Total NREG rf_we pulses.
- Reset mid-CLEAR: abort immediately to the reset values; partial clear is acceptable.
- rf_we is a single-cycle pulse per write and is never asserted without a transfer or a clear step.
- Width rules:
  - clr_cnt is AW+1 bits so that NREG=2**AW terminates correctly.
  - grant_id is zero-extended.

Optional Feature:
- Macro REGW_ZERO_GUARD_EN.
- Defined:
  - A granted request with req_addr=0 is still handshaken (ready=1), but next cycle rf_we=0, so $zero is never written by requesters.
  - An extra output zero_drop (1 bit) pulses 1 for one cycle when this happens.
  - Clear writes to address 0 are unaffected.
- Undefined: address 0 is written like any other; no zero_drop port.

Decomposition:
- Package regfile_pkg:
  - Constants RF_AW=5, RF_DW=32, RF_NREG=32.
  - State enum {ST_IDLE, ST_CLEAR}.
  - Function for the packed-slice index.
- Sub-module rr_arbiter (NREQ-wide):
  - Combinational round-robin priority pick from req_valid and rr_ptr.
  - Outputs a one-hot grant and the winner index.
- The top level holds the FSM, clear counter and output registers.

Test Plan:
- Reset then idle: hold res_n=0 for 2 cycles, then release with no valid -> rf_we=0, clr_busy=0, req_ready=000 for 10 cycles.
- Single write: req_valid=001, addr=5'd7, data=32'hDEADBEEF -> req_ready=001 the same cycle; next cycle rf_we=1, rf_waddr=7, rf_wdata=DEADBEEF, grant_id=0.
- Fairness: all three valid held continuously for 6 transfers -> grant_id sequence 0,1,2,0,1,2 with rf_we=1 every cycle.
- Clear vs request: clr_start=1 with req_valid=010 in IDLE -> req_ready=000, then 32 consecutive rf_we pulses with addr 0..31 and data 0. Requester 1 is granted the cycle after the last clear write.
- Reset mid-clear: assert res_n=0 after clear addr 10 -> next edge rf_we=0, clr_busy=0; a new clr_start restarts from addr 0.
- REGW_ZERO_GUARD_EN defined: request addr=0, data=32'h1 -> ready=1, next cycle rf_we=0 and zero_drop=1. Undefined: rf_we=1, rf_waddr=0.

Source files
------------

// File: rtl/regfile_write_sched_pkg.sv
// Shared constants, FSM state type and packed-slice helper for the register-file write scheduler.
package regfile_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  // Low bit of requester idx's field inside a packed bus of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_write_sched_if.sv
// Writeback requester handshake bus: packed valid/addr/data towards the scheduler, one-hot ready back.
interface regfile_write_sched_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);

endinterface

// File: rtl/regfile_write_sched_arbiter.sv
// Combinational round-robin pick: first valid requester after rr_ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner,
  output logic            any_valid
);

  int  idx;
  logic found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/regfile_write_sched.sv
// Single write-port scheduler for the register file: round-robin writeback plus a sequenced clear.
// Optional macro REGW_ZERO_GUARD_EN drops requester writes to $zero and adds the zero_drop pulse.
module regfile_write_sched
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW,
  parameter int NREG = RF_NREG
) (
  input  logic                  clock_in,
  input  logic                  res_n,
  regfile_write_sched_if.slave  req,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
`ifdef REGW_ZERO_GUARD_EN
  output logic                  zero_drop,
`endif
  output logic [1:0]            grant_id
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] CLR_LAST = (AW + 1)'(NREG - 1);

  state_t          state;
  logic [AW:0]     clr_cnt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   winner;
  logic [NREQ-1:0] grant;
  logic            any_valid;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .valid     (req.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    win_addr = req.req_addr[slice_lo(int'(winner), AW) +: AW];
    win_data = req.req_data[slice_lo(int'(winner), DW) +: DW];
  end

  // A pending clear request outranks requesters in the same cycle.
  assign req.req_ready = (res_n && state == ST_IDLE && !clr_start) ? grant : '0;

  always_ff @(posedge clock_in) begin
    if (!res_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= PW'(NREQ - 1);
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= '0;
`ifdef REGW_ZERO_GUARD_EN
      zero_drop <= 1'b0;
`endif
    end else begin
`ifdef REGW_ZERO_GUARD_EN
      zero_drop <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
            rf_we    <= 1'b0;
          end else begin
            clr_busy <= 1'b0;
            if (any_valid) begin
              rr_ptr   <= winner;
              grant_id <= 2'(winner);
`ifdef REGW_ZERO_GUARD_EN
              if (win_addr == '0) begin
                rf_we     <= 1'b0;
                zero_drop <= 1'b1;
              end else begin
                rf_we    <= 1'b1;
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
              end
`else
              rf_we    <= 1'b1;
              rf_waddr <= win_addr;
              rf_wdata <= win_data;
`endif
            end else begin
              rf_we <= 1'b0;
            end
          end
        end
        ST_CLEAR: begin
          // clr_busy stays high through the cycle that holds the final write.
          rf_we    <= 1'b1;
          rf_waddr <= clr_cnt[AW-1:0];
          rf_wdata <= '0;
          if (clr_cnt == CLR_LAST) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed testbench for regfile_write_sched; follows REGW_ZERO_GUARD_EN when the macro is defined.
module tb_regfile_write_sched;

  logic        clk = 1'b0;
  logic        res_n;
  logic        clr_start;
  logic        clr_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  grant_id;
`ifdef REGW_ZERO_GUARD_EN
  logic        zero_drop;
`endif

  int checks = 0;
  int failures = 0;

  regfile_write_sched_if #(.NREQ(3), .AW(5), .DW(32)) bus ();

  regfile_write_sched #(.NREQ(3), .AW(5), .DW(32), .NREG(32)) dut (
    .clock_in  (clk),
    .res_n     (res_n),
    .req       (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
`ifdef REGW_ZERO_GUARD_EN
    .zero_drop (zero_drop),
`endif
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*5 +: 5]   = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    step();
    step();
    res_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = 3'b111;
    res_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.req_ready !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b exp=000", bus.req_ready);
    end
    checks++;
    if ({rf_we, clr_busy, rf_waddr, rf_wdata, grant_id} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs we=%b busy=%b addr=%0d data=%h gid=%0d exp all 0",
               rf_we, clr_busy, rf_waddr, rf_wdata, grant_id);
    end
    bus.req_valid = 3'b000;
    res_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (rf_we !== 1'b0 || clr_busy !== 1'b0 || bus.req_ready !== 3'b000) begin
        failures++;
        $display("[TB] FAIL idle_quiet cyc=%0d we=%b busy=%b ready=%b exp 0/0/000",
                 c, rf_we, clr_busy, bus.req_ready);
      end
    end
  endtask

  task automatic test_single_write();
    set_req(0, 5'd7, 32'hDEADBEEF);
    bus.req_valid = 3'b001;
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      failures++;
      $display("[TB] FAIL single_ready got=%b exp=001", bus.req_ready);
    end
    step();
    bus.req_valid = 3'b000;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF || grant_id !== 2'd0) begin
      failures++;
      $display("[TB] FAIL single_write we=%b addr=%0d data=%h gid=%0d exp 1/7/deadbeef/0",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL single_hold we=%b addr=%0d data=%h exp 0/7/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_ready;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
    bus.req_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      exp_ready = 3'b001 << (t % 3);
      #1;
      checks++;
      if (bus.req_ready !== exp_ready) begin
        failures++;
        $display("[TB] FAIL fair_ready t=%0d got=%b exp=%b", t, bus.req_ready, exp_ready);
      end
      step();
      checks++;
      if (rf_we !== 1'b1 || grant_id !== 2'(t % 3) || rf_waddr !== 5'((t % 3) + 1) ||
          rf_wdata !== 32'h100 + 32'(t % 3)) begin
        failures++;
        $display("[TB] FAIL fair_write t=%0d we=%b gid=%0d addr=%0d data=%h exp 1/%0d/%0d/%h",
                 t, rf_we, grant_id, rf_waddr, rf_wdata, t % 3, (t % 3) + 1, 32'h100 + 32'(t % 3));
      end
    end
    bus.req_valid = 3'b000;
    step();
  endtask

  task automatic test_clear_vs_request();
    logic [2:0] exp_ready;
    do_reset();
    set_req(1, 5'd19, 32'hCAFE0001);
    bus.req_valid = 3'b010;
    clr_start = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 3'b000) begin
      failures++;
      $display("[TB] FAIL clr_priority_ready got=%b exp=000", bus.req_ready);
    end
    step();
    clr_start = 1'b0;
    checks++;
    if (clr_busy !== 1'b1 || rf_we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clr_accept busy=%b we=%b exp 1/0", clr_busy, rf_we);
    end
    for (int a = 0; a < 32; a++) begin
      step();
      exp_ready = (a == 31) ? 3'b010 : 3'b000;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(a) || rf_wdata !== 32'd0 || clr_busy !== 1'b1 ||
          bus.req_ready !== exp_ready) begin
        failures++;
        $display("[TB] FAIL clr_step a=%0d we=%b addr=%0d data=%h busy=%b ready=%b exp 1/%0d/0/1/%b",
                 a, rf_we, rf_waddr, rf_wdata, clr_busy, bus.req_ready, a, exp_ready);
      end
    end
    step();
    bus.req_valid = 3'b000;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd19 || rf_wdata !== 32'hCAFE0001 || grant_id !== 2'd1 ||
        clr_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clr_then_req we=%b addr=%0d data=%h gid=%0d busy=%b exp 1/19/cafe0001/1/0",
               rf_we, rf_waddr, rf_wdata, grant_id, clr_busy);
    end
    step();
  endtask

  task automatic test_reset_mid_clear();
    bit done;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int a = 0; a <= 10; a++) step();
    checks++;
    if (rf_waddr !== 5'd10 || rf_we !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midclr_pos addr=%0d we=%b exp 10/1", rf_waddr, rf_we);
    end
    res_n = 1'b0;
    step();
    checks++;
    if (rf_we !== 1'b0 || clr_busy !== 1'b0 || rf_waddr !== 5'd0) begin
      failures++;
      $display("[TB] FAIL midclr_abort we=%b busy=%b addr=%0d exp 0/0/0", rf_we, clr_busy, rf_waddr);
    end
    res_n = 1'b1;
    step();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd0) begin
      failures++;
      $display("[TB] FAIL midclr_restart0 we=%b addr=%0d exp 1/0", rf_we, rf_waddr);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd1) begin
      failures++;
      $display("[TB] FAIL midclr_restart1 we=%b addr=%0d exp 1/1", rf_we, rf_waddr);
    end
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (clr_busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL midclr_timeout busy=%b exp 0 within 40 cycles", clr_busy);
    end
  endtask

  task automatic test_zero_addr();
    set_req(2, 5'd0, 32'h1);
    bus.req_valid = 3'b100;
    #1;
    checks++;
    if (bus.req_ready !== 3'b100) begin
      failures++;
      $display("[TB] FAIL zero_ready got=%b exp=100", bus.req_ready);
    end
    step();
    bus.req_valid = 3'b000;
`ifdef REGW_ZERO_GUARD_EN
    checks++;
    if (rf_we !== 1'b0 || zero_drop !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_guard we=%b drop=%b exp 0/1", rf_we, zero_drop);
    end
    step();
    checks++;
    if (zero_drop !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_drop_pulse drop=%b exp 0", zero_drop);
    end
`else
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd0 || rf_wdata !== 32'h1 || grant_id !== 2'd2) begin
      failures++;
      $display("[TB] FAIL zero_write we=%b addr=%0d data=%h gid=%0d exp 1/0/1/2",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
    step();
`endif
  endtask

  initial begin
    res_n = 1'b0;
    clr_start = 1'b0;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    test_reset();
    test_single_write();
    test_fairness();
    test_clear_vs_request();
    test_reset_mid_clear();
    test_zero_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
